// File: rtl/riscy_pkg.sv
// Shared encodings for the RV32 single-cycle control path.
// Holds opcodes, ALU/immediate/result selects and flag bit indices.
package riscy_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  localparam logic [2:0] F3_SR = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_U = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [1:0] imm_src;
    logic [1:0] result_src;
    logic [3:0] alu_control;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/branch_unit.sv
// Branch condition resolver: funct3 selects a test on ALU flags.
// Ports: funct3 [2:0], flags {N,Z,C,V} [3:0] in; taken out.
module branch_unit
  import riscy_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Unsigned compare uses carry-as-not-borrow from a - b.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      BR_EQ:   taken = z;
      BR_NE:   taken = ~z;
      BR_LT:   taken = n ^ v;
      BR_GE:   taken = ~(n ^ v);
      BR_LTU:  taken = ~c;
      BR_GEU:  taken = c;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Main decoder for the single-cycle RV32 core; purely combinational.
// Ports: clk, rst, op, funct3, funct7, flags in; datapath controls out.
module control_unit
  import riscy_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic [3:0] flags,
  output logic       RegWrite,
  output logic       ALUSrc,
  output logic       MemWrite,
  output logic       PCSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] ResultSrc,
  output logic [3:0] ALUControl
);

  // Clock is carried only for interface uniformity.
  logic unused_clk;
  assign unused_clk = clk;

  ctrl_t ctrl;
  ctrl_t ctrl_out;
  logic  taken;

  branch_unit u_branch (
    .funct3 (funct3),
    .flags  (flags),
    .taken  (taken)
  );

  always_comb begin
    ctrl = CTRL_NOP;
    case (op)
      OP_R: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = {funct7, funct3};
      end
      OP_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        // funct7[5] only distinguishes srli/srai.
        if (funct3 == F3_SR)
          ctrl.alu_control = {funct7, funct3};
        else
          ctrl.alu_control = {1'b0, funct3};
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
      end
      OP_STORE: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.imm_src   = IMM_S;
      end
      OP_BRANCH: begin
        ctrl.alu_src     = 1'b1;
        ctrl.mem_write   = 1'b1;
        ctrl.imm_src     = IMM_S;
        ctrl.branch      = 1'b1;
        ctrl.alu_control = ALU_SUB;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.imm_src    = IMM_J;
        ctrl.result_src = RES_PC4;
        ctrl.jump       = 1'b1;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.imm_src   = IMM_U;
      end
      default: ctrl = CTRL_NOP;
    endcase
  end

  always_comb begin
    ctrl_out = ctrl;
    if (rst)
      ctrl_out = CTRL_NOP;
  end

  assign RegWrite   = ctrl_out.reg_write;
  assign ALUSrc     = ctrl_out.alu_src;
  assign MemWrite   = ctrl_out.mem_write;
  assign ImmSrc     = ctrl_out.imm_src;
  assign ResultSrc  = ctrl_out.result_src;
  assign ALUControl = ctrl_out.alu_control;
  assign PCSrc      = ctrl_out.jump
                    | (ctrl_out.branch & taken);

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit.
// Output bundle: {RegWrite,ALUSrc,MemWrite,PCSrc,ImmSrc,ResultSrc,ALUControl}.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic [3:0] flags;
  logic       RegWrite;
  logic       ALUSrc;
  logic       MemWrite;
  logic       PCSrc;
  logic [1:0] ImmSrc;
  logic [1:0] ResultSrc;
  logic [3:0] ALUControl;

  int n_checks = 0;
  int n_fail   = 0;

  control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7     (funct7),
    .flags      (flags),
    .RegWrite   (RegWrite),
    .ALUSrc     (ALUSrc),
    .MemWrite   (MemWrite),
    .PCSrc      (PCSrc),
    .ImmSrc     (ImmSrc),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] outs;
  assign outs = {RegWrite, ALUSrc, MemWrite, PCSrc,
                 ImmSrc, ResultSrc, ALUControl};

  task automatic apply(input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic [3:0] fl);
    @(negedge clk);
    op = o; funct3 = f3; funct7 = f7; flags = fl;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    apply(7'b1101111, 3'b000, 1'b0, 4'b0000);
    n_checks++;
    if (outs !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_jal got %b want %b", outs, 13'b0);
    end
    apply(7'b0100011, 3'b010, 1'b0, 4'b1111);
    n_checks++;
    if (outs !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_store got %b want %b", outs, 13'b0);
    end
    // Release mid-cycle: decode must show up without a clock edge.
    rst = 1'b0;
    #1;
    n_checks++;
    if (outs !== 13'b0_1_1_0_01_00_0000) begin
      n_fail++;
      $display("FAIL reset_release got %b want %b",
               outs, 13'b0_1_1_0_01_00_0000);
    end
  endtask

  task automatic test_rtype;
    logic [12:0] exp;
    apply(7'b0110011, 3'b000, 1'b0, 4'b0000);
    exp = 13'b1_0_0_0_00_00_0000;
    n_checks++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL rtype_add got %b want %b", outs, exp);
    end
    apply(7'b0110011, 3'b000, 1'b1, 4'b0000);
    exp = 13'b1_0_0_0_00_00_1000;
    n_checks++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL rtype_sub got %b want %b", outs, exp);
    end
    apply(7'b0110011, 3'b111, 1'b1, 4'b1111);
    exp = 13'b1_0_0_0_00_00_1111;
    n_checks++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL rtype_f111_flags got %b want %b", outs, exp);
    end
  endtask

  task automatic test_iarith;
    logic [12:0] exp;
    apply(7'b0010011, 3'b000, 1'b0, 4'b0000);
    exp = 13'b1_1_0_0_00_00_0000;
    n_checks++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL iarith_addi got %b want %b", outs, exp);
    end
    apply(7'b0010011, 3'b000, 1'b1, 4'b0000);
    n_checks++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL iarith_f7_ignored got %b want %b", outs, exp);
    end
    apply(7'b0010011, 3'b101, 1'b1, 4'b0000);
    exp = 13'b1_1_0_0_00_00_1101;
    n_checks++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL iarith_srai got %b want %b", outs, exp);
    end
    apply(7'b0010011, 3'b101, 1'b0, 4'b0000);
    exp = 13'b1_1_0_0_00_00_0101;
    n_checks++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL iarith_srli got %b want %b", outs, exp);
    end
    apply(7'b0010011, 3'b110, 1'b1, 4'b0000);
    exp = 13'b1_1_0_0_00_00_0110;
    n_checks++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL iarith_ori got %b want %b", outs, exp);
    end
  endtask

  task automatic test_mem;
    logic [12:0] exp;
    apply(7'b0000011, 3'b010, 1'b1, 4'b0000);
    exp = 13'b1_1_0_0_00_01_0000;
    n_checks++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL load got %b want %b", outs, exp);
    end
    apply(7'b0100011, 3'b010, 1'b1, 4'b0000);
    exp = 13'b0_1_1_0_01_00_0000;
    n_checks++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL store got %b want %b", outs, exp);
    end
  endtask

  task automatic test_jal_lui;
    logic [12:0] exp;
    apply(7'b1101111, 3'b000, 1'b0, 4'b0000);
    exp = 13'b1_0_0_1_11_10_0000;
    n_checks++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL jal got %b want %b", outs, exp);
    end
    apply(7'b0110111, 3'b000, 1'b1, 4'b1111);
    exp = 13'b1_0_0_0_10_00_0000;
    n_checks++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL lui got %b want %b", outs, exp);
    end
  endtask

  task automatic test_branch;
    logic [12:0] exp;
    logic [2:0]  f3_t [14];
    logic [3:0]  fl_t [14];
    logic        pc_t [14];
    f3_t = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100, 3'b100, 3'b101,
             3'b101, 3'b110, 3'b110, 3'b111, 3'b111, 3'b010, 3'b011};
    fl_t = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b1001, 4'b1000,
             4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0100, 4'b1111};
    pc_t = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
             1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    apply(7'b1100011, 3'b000, 1'b0, 4'b0000);
    exp = 13'b0_1_1_0_01_00_1000;
    n_checks++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL branch_ctrl got %b want %b", outs, exp);
    end
    for (int i = 0; i < 14; i++) begin
      apply(7'b1100011, f3_t[i], 1'b1, fl_t[i]);
      n_checks++;
      if (PCSrc !== pc_t[i]) begin
        n_fail++;
        $display("FAIL branch_%0d f3=%b flags=%b PCSrc got %b want %b",
                 i, f3_t[i], fl_t[i], PCSrc, pc_t[i]);
      end
    end
    apply(7'b0110011, 3'b000, 1'b0, 4'b0100);
    n_checks++;
    if (PCSrc !== 1'b0) begin
      n_fail++;
      $display("FAIL nonbranch_pcsrc got %b want 0", PCSrc);
    end
  endtask

  task automatic test_unknown;
    apply(7'b1111111, 3'b111, 1'b1, 4'b1111);
    n_checks++;
    if (outs !== 13'b0) begin
      n_fail++;
      $display("FAIL unknown_7f got %b want %b", outs, 13'b0);
    end
    apply(7'b0000000, 3'b000, 1'b0, 4'b0100);
    n_checks++;
    if (outs !== 13'b0) begin
      n_fail++;
      $display("FAIL unknown_00 got %b want %b", outs, 13'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    op = '0; funct3 = '0; funct7 = 1'b0; flags = '0;
    test_reset;
    test_rtype;
    test_iarith;
    test_mem;
    test_jal_lui;
    test_branch;
    test_unknown;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
